// File: rtl/uart_rx_os16.sv
// ---------------------------------------------------------------------------
// uart_rx_os16 - 8N1 UART receiver with 16x oversampling.
//
// Consumes the serial line driven by the companion UART transmitter and
// turns each start/8-data/stop frame back into a byte. Bit timing comes from
// the shared oversample strobe boud_in (OS_RATE strobes per bit). The start
// bit is qualified at its centre and every later bit is sampled one full bit
// period after the previous sample, so all samples sit at bit centres.
//
// Ports:
//   clk        in   system clock, rising-edge
//   rst        in   synchronous active-high reset
//   boud_in    in   oversample strobe, one clk wide, OS_RATE per bit
//   rx         in   asynchronous serial line, idles high
//   rx_data    out  last good byte; held until the next good frame
//   rx_valid   out  1-cycle pulse when rx_data is updated
//   frame_err  out  1-cycle pulse when the stop bit samples low
//   busy       out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_os16 #(
  parameter int DATA_BITS = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int OS_RATE   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boud_in,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int            TW       = $clog2(OS_RATE);
  localparam logic [TW-1:0] TICK_MID = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OS_RATE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_frame_err;

  // Two-flop synchroniser plus a delayed copy for edge detection. All three
  // reset to the idle level so a reset never fabricates a falling edge.
  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_d;

  logic       w_fall;
  logic [7:0] w_shift_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  // Requires a high-to-low transition, so a line parked low (break, or the
  // tail of a bad stop bit) cannot start a new frame.
  assign w_fall = r_rx_d & ~r_rx_s;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift[6:0], r_rx_s};
    end else begin : g_lsb_first
      assign w_shift_next = {r_rx_s, r_shift[7:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
          end
        end

        ST_START: begin
          if (boud_in) begin
            if (r_tick_cnt == TICK_MID) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              // Still low at mid start bit: genuine start. Otherwise a glitch.
              r_state    <= r_rx_s ? ST_IDLE : ST_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (boud_in) begin
            if (r_tick_cnt == TICK_END) begin
              r_tick_cnt <= '0;
              r_shift    <= w_shift_next;
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == LAST_BIT) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (boud_in) begin
            if (r_tick_cnt == TICK_END) begin
              // Returning to idle at mid stop bit re-arms the receiver early
              // enough to catch a back-to-back start edge.
              r_tick_cnt <= '0;
              r_state    <= ST_IDLE;
              if (r_rx_s) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_os16 - self-checking bench for uart_rx_os16.
//
// boud_in pulses once every 4 clk, so one bit lasts 64 clk. Frames are sent
// MSB first. Each frame's expected outcome (good byte or framing error) is
// queued before it is sent; a compare process checks every cycle that pulses
// match the queue in order and that rx_data holds between good frames.
// ---------------------------------------------------------------------------
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       boud_in = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_os16 #(
    .DATA_BITS(8),
    .MSB_FIRST(1'b1),
    .OS_RATE  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .boud_in  (boud_in),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         stop_start = 0;
  int         div = 0;
  bit         baud_en = 1'b1;
  bit         armed = 1'b0;
  bit         prev_pulse = 1'b0;
  logic [7:0] model_data = 8'h00;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Baud strobe: one clk high in every four, suppressed while stalled.
  initial forever begin
    @(negedge clk);
    boud_in = baud_en && (div == 0);
    div = (div + 1) % 4;
  end

  // Compare process: sampled 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (armed && !rst) begin
      if (rx_valid || frame_err) begin
        pulses++;
        chk("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
        chk("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
        chk("busy_at_pulse", {31'd0, busy}, 32'd0);
        checks++;
        if ((cyc - stop_start) < 28 || (cyc - stop_start) > 44) begin
          errors++;
          $display("FAIL pulse_latency: got %0d clk after stop start expected 28..44",
                   cyc - stop_start);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none (cycle %0d)",
                   rx_valid, frame_err, cyc);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          if (frame_err !== ev.is_err) begin
            errors++;
            $display("FAIL pulse_kind: got frame_err=%0b expected %0b", frame_err, ev.is_err);
          end
          if (!ev.is_err) model_data = ev.data;
          chk("rx_data_at_pulse", {24'd0, rx_data}, {24'd0, model_data});
        end
      end else begin
        chk("rx_data_hold", {24'd0, rx_data}, {24'd0, model_data});
      end
      prev_pulse = rx_valid | frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(logic b, bit stall);
    rx = b;
    if (stall) begin
      wait_clk(32);
      baud_en = 1'b0;
      wait_clk(200);
      baud_en = 1'b1;
      wait_clk(32);
    end else begin
      wait_clk(64);
    end
  endtask

  task automatic send_frame(logic [7:0] d, logic stop_v, int stall_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[7-i], i == stall_bit);
    stop_start = cyc;
    send_bit(stop_v, 1'b0);
  endtask

  task automatic expect_byte(logic [7:0] d);
    ev_t ev;
    ev.is_err = 1'b0;
    ev.data   = d;
    exp_q.push_back(ev);
  endtask

  task automatic expect_err();
    ev_t ev;
    ev.is_err = 1'b1;
    ev.data   = 8'h00;
    exp_q.push_back(ev);
  endtask

  int         p0;
  logic [7:0] abort_byte;

  initial begin
    // Reset state
    rst = 1'b1;
    wait_clk(4);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    armed = 1'b1;
    wait_clk(64);

    // Good frame 0xA5
    p0 = pulses;
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    wait_clk(64);
    chk("a5_pulse_count", pulses, p0 + 1);
    chk("a5_rx_data", {24'd0, rx_data}, 32'hA5);
    chk("a5_busy_idle", {31'd0, busy}, 32'd0);
    $display("txn good_frame: rx_data=%02h pulses=%0d", rx_data, pulses - p0);

    // Glitch of 12 clk, then frame 0x3C
    p0 = pulses;
    rx = 1'b0;
    wait_clk(10);
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_clk(2);
    rx = 1'b1;
    wait_clk(32);
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);
    chk("glitch_no_pulse", pulses, p0);
    wait_clk(64);
    expect_byte(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    wait_clk(64);
    chk("post_glitch_count", pulses, p0 + 1);
    chk("post_glitch_rx_data", {24'd0, rx_data}, 32'h3C);
    $display("txn glitch_then_frame: rx_data=%02h pulses=%0d", rx_data, pulses - p0);

    // Bad stop bit, then frame 0x81
    p0 = pulses;
    expect_err();
    send_frame(8'h3C, 1'b0, -1);
    rx = 1'b1;
    wait_clk(64);
    chk("bad_stop_count", pulses, p0 + 1);
    chk("bad_stop_rx_data", {24'd0, rx_data}, 32'h3C);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1, -1);
    wait_clk(64);
    chk("after_err_count", pulses, p0 + 2);
    chk("after_err_rx_data", {24'd0, rx_data}, 32'h81);
    $display("txn bad_stop_then_frame: rx_data=%02h pulses=%0d", rx_data, pulses - p0);

    // Back-to-back frames
    p0 = pulses;
    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'h55);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    wait_clk(64);
    chk("b2b_count", pulses, p0 + 3);
    chk("b2b_rx_data", {24'd0, rx_data}, 32'h55);
    $display("txn back_to_back: rx_data=%02h pulses=%0d", rx_data, pulses - p0);

    // Reset after 4 data bits of 0x0F; remaining bits are all high
    p0 = pulses;
    abort_byte = 8'h0F;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(abort_byte[7-i], 1'b0);
    rx = abort_byte[3];
    wait_clk(32);
    rst = 1'b1;
    model_data = 8'h00;
    wait_clk(1);
    chk("midreset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clk(32);
    for (int i = 5; i < 8; i++) send_bit(abort_byte[7-i], 1'b0);
    send_bit(1'b1, 1'b0);
    wait_clk(64);
    chk("aborted_no_pulse", pulses, p0);
    expect_byte(8'hC3);
    send_frame(8'hC3, 1'b1, -1);
    wait_clk(64);
    chk("post_reset_count", pulses, p0 + 1);
    chk("post_reset_rx_data", {24'd0, rx_data}, 32'hC3);
    $display("txn reset_mid_frame: rx_data=%02h pulses=%0d", rx_data, pulses - p0);

    // Baud stall of 200 clk inside frame 0x5A
    p0 = pulses;
    expect_byte(8'h5A);
    send_frame(8'h5A, 1'b1, 3);
    wait_clk(64);
    chk("stall_count", pulses, p0 + 1);
    chk("stall_rx_data", {24'd0, rx_data}, 32'h5A);
    chk("stall_busy_idle", {31'd0, busy}, 32'd0);
    $display("txn baud_stall: rx_data=%02h pulses=%0d", rx_data, pulses - p0);

    chk("expect_queue_drained", exp_q.size(), 0);
    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver; the downstream stage of the UART transmitter in the same codebase, and it consumes the transmitter's serial line.
- Uses 16x oversampling driven by the shared baud-tick strobe.
- Deserialises 8N1 frames (start, 8 data bits, stop) into a byte.
- Reports each byte with a 1-cycle valid pulse and flags stop-bit errors.

Parameters:
- DATA_BITS, 8, payload bits per frame (only 8 is supported).
- MSB_FIRST, 1, 1 = first data bit received is bit 7 (matches the transmitter); 0 = LSB first.
- OS_RATE, 16, baud ticks per bit. Counter width is log2(OS_RATE); must be a power of 2 and at least 4.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  reset, active-high, synchronous (sampled on the clk rising edge).
- boud_in  in  1  oversample strobe at 16x the baud rate. One clk cycle wide when high.
- rx  in  1  serial line, asynchronous, idles high.
- rx_data  out  8  last received byte; holds its value until the next frame completes.
- rx_valid  out  1  1-cycle pulse when rx_data updates with a good frame.
- frame_err  out  1  1-cycle pulse when the stop bit samples low.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Input sync: rx passes through a 2-flop synchroniser (rx_s); both flops reset to 1. Edge detect uses rx_s and its one-cycle-delayed copy, which also resets to 1.
- Reset: state=IDLE, tick_cnt=0, bit_cnt=0, shift=0, rx_data=0x00, rx_valid=0, frame_err=0, busy=0. A reset mid-frame abandons the frame with no pulse.
- tick_cnt advances only on cycles where boud_in=1. With boud_in stuck low, all state is frozen.
- IDLE:
  - A falling edge on rx_s (previous 1, current 0) moves to START with tick_cnt=0.
  - A line held low does not retrigger; a high must be seen first.
- START:
  - Sample on the boud_in cycle where tick_cnt==7 (mid start bit).
  - rx_s=0 -> DATA, with tick_cnt=0 and bit_cnt=0.
  - rx_s=1 -> false start -> IDLE, with no pulse.
- DATA:
  - Sample on the boud_in cycle where tick_cnt==15; tick_cnt wraps to 0 on that cycle.
  - Sample placement: 16 ticks after the mid-start sample, so every sample lands at a bit centre.
  - MSB_FIRST=1: shift = {shift[6:0], rx_s}. MSB_FIRST=0: shift = {rx_s, shift[7:1]}.
  - bit_cnt increments on each sample. After the 8th sample (bit_cnt==7) -> STOP.
- STOP:
  - Sample at tick_cnt==15, then go to IDLE in the same cycle.
  - rx_s=1: rx_data<=shift and rx_valid=1 in the next cycle.
  - rx_s=0: frame_err=1 in the next cycle; rx_data is unchanged and rx_valid stays 0.
- Latency: rx_valid/frame_err is high exactly one clk after the stop-sample cycle. The stop-sample cycle is the 8th tick of the stop bit.
- Back-to-back frames: after a good stop, IDLE sees the next start edge with no extra idle bit required. The receiver is re-armed ~half a bit before the nominal stop end.
- Break / line stuck low after a frame error: there is no new frame until rx_s returns high and falls again.
- rx_valid and frame_err are never high together, and each is a single-cycle pulse.
- busy: combinational (state != IDLE). It is 0 in the cycle the pulses assert.

Test Plan (bench drives boud_in high 1 cycle in every 4 clk, so 1 bit = 64 clk; frames are sent MSB first):
- Good frame 0xA5, idle high before and after -> rx_data=0xA5, a single rx_valid pulse, frame_err never asserted, busy back to 0.
- Glitch: rx low for 12 clk (3 ticks), then high -> no rx_valid or frame_err, busy falls within 8 ticks, and a following frame 0x3C is received correctly.
- Bad stop: frame 0x3C with the stop bit driven 0, then line high; then frame 0x81 -> one frame_err pulse, rx_data stays at its prior value; then rx_data=0x81 with rx_valid.
- Back-to-back 0x00, 0xFF, 0x55 with no idle bits between frames -> three rx_valid pulses with rx_data 0x00, 0xFF, 0x55 in order.
- rst asserted for 1 cycle mid-DATA (after 4 bits) -> next cycle all outputs 0 and busy=0; the remainder of the aborted frame yields no pulse; a subsequent clean frame 0xC3 is received correctly.
- boud_in held 0 for 200 clk in the middle of a 0x5A frame, then resumed -> the frame completes with rx_data=0x5A, one valid pulse, and no spurious pulse during the stall.
